// File: rtl/rsmem_issue_pipe_pkg.sv
// Shared widths and RS memory entry layout for the memory issue pipe.
package rsmem_issue_pipe_pkg;

  localparam int RS_MEM_ISSUE_REQ = 2;
  localparam int SPEC_STATES      = 4;
  localparam int RS_MEM_PC_W      = 32;
  localparam int RS_MEM_OP_W      = 3;
  localparam int RS_MEM_LEN       = RS_MEM_PC_W + RS_MEM_OP_W + 1 + SPEC_STATES;

  // Field positions inside one RS memory entry (LSB first).
  localparam int RS_MEM_KILLMASK_LSB = 0;
  localparam int RS_MEM_ISST         = SPEC_STATES;
  localparam int RS_MEM_OP_LSB       = RS_MEM_ISST + 1;
  localparam int RS_MEM_PC_LSB       = RS_MEM_OP_LSB + RS_MEM_OP_W;

  typedef struct packed {
    logic [RS_MEM_PC_W-1:0] pc;
    logic [RS_MEM_OP_W-1:0] op;
    logic                   isst;
    logic [SPEC_STATES-1:0] killmask;
  } rs_mem_entry_t;

endpackage

// File: rtl/rsmem_issue_slot.sv
// One memory-port holding register: grant capture, valid/ready drain,
// branch kill, kill-mask update and flush.
module rsmem_issue_slot
  import rsmem_issue_pipe_pkg::*;
#(
  parameter int ENTRY_LEN = RS_MEM_LEN,
  parameter int SPEC_W    = SPEC_STATES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 kill_enable_i,
  input  logic                 update_killmask_i,
  input  logic [SPEC_W-1:0]    spec_tag_i,
  input  logic                 grant_i,
  input  logic [ENTRY_LEN-1:0] req_entry_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [ENTRY_LEN-1:0] entry_o,
  output logic                 free_o
);

  logic                 hv_q, hv_d;
  logic [ENTRY_LEN-1:0] hd_q, hd_d;
  logic [ENTRY_LEN-1:0] req_masked, hold_masked;
  logic                 kill_hold, fire, clear_en;

  assign kill_hold = kill_enable_i & (|(spec_tag_i & hd_q[RS_MEM_KILLMASK_LSB +: SPEC_W]));
  assign valid_o   = hv_q & ~kill_hold;
  assign fire      = valid_o & ready_i;
  assign free_o    = ~hv_q | fire | kill_hold;
  assign entry_o   = hd_q;

  // A simultaneous kill wins over a mask update, so the clear is suppressed then.
  assign clear_en = update_killmask_i & ~kill_enable_i;

  // NOTE: combinational blocks use blocking '=' with a default assignment
  // first, so every path assigns every output and no latch is inferred.
  always_comb begin
    req_masked  = req_entry_i;
    hold_masked = hd_q;
    if (clear_en) begin
      req_masked[RS_MEM_KILLMASK_LSB +: SPEC_W]  = req_entry_i[RS_MEM_KILLMASK_LSB +: SPEC_W] & ~spec_tag_i;
      hold_masked[RS_MEM_KILLMASK_LSB +: SPEC_W] = hd_q[RS_MEM_KILLMASK_LSB +: SPEC_W] & ~spec_tag_i;
    end
  end

  always_comb begin
    hv_d = hv_q;
    hd_d = hd_q;
    if (flush_i) begin
      hv_d = 1'b0;
    end else if (grant_i) begin
      hv_d = 1'b1;
      hd_d = req_masked;
    end else if (fire || kill_hold) begin
      hv_d = 1'b0;
    end else begin
      hd_d = hold_masked;
    end
  end

  // NOTE: the data register is reset too, even though it is only meaningful
  // while hv_q is set; this keeps the port outputs at zero throughout reset.
  // Sequential state is always written with non-blocking '<='.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hv_q <= 1'b0;
      hd_q <= '0;
    end else begin
      hv_q <= hv_d;
      hd_q <= hd_d;
    end
  end

endmodule

// File: rtl/rsmem_issue_pipe.sv
// Memory RS issue-select and per-port issue registers.
// Optional perf counters are built when RSMEM_ISSUE_PERF_EN is defined.
module rsmem_issue_pipe
  import rsmem_issue_pipe_pkg::*;
#(
  parameter int NUM_REQ   = RS_MEM_ISSUE_REQ,
  parameter int ENTRY_LEN = RS_MEM_LEN,
  parameter int SPEC_W    = SPEC_STATES,
  parameter int PERF_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Stall,
  input  logic                         Flush,
  input  logic                         Kill_Enable,
  input  logic                         Update_KillMask,
  input  logic [SPEC_W-1:0]            FUBR_SpecTag,
  input  logic [NUM_REQ*ENTRY_LEN-1:0] RSMEM_IssueReq_Entries,
  input  logic [NUM_REQ-1:0]           RSMEM_IssueReq_Valid,
  output logic [NUM_REQ-1:0]           RSMEM_Issued_Valid,
  input  logic [NUM_REQ-1:0]           MEMP_Ready,
  output logic [NUM_REQ*ENTRY_LEN-1:0] MEMP_Entries,
  output logic [NUM_REQ-1:0]           MEMP_Valid,
  output logic [PERF_W-1:0]            MemIssue_Count,
  output logic [PERF_W-1:0]            MemIssue_BlockCycles
);

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] slot_free;
  logic [NUM_REQ-1:0] kill_req;
  logic               grant_ok;

  // Grants are suppressed while reset is asserted so the RS never sees a
  // confirmation for a uop that was not captured.
  assign grant_ok = rst & ~Stall & ~Flush;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      kill_req[i] = Kill_Enable &
                    (|(FUBR_SpecTag & RSMEM_IssueReq_Entries[i*ENTRY_LEN + RS_MEM_KILLMASK_LSB +: SPEC_W]));
    end
  end

  // Strict age order: each lane needs all older lanes granted, and only one
  // store may issue per cycle because there is a single store-data path.
  always_comb begin
    logic prev_granted;
    logic store_taken;
    logic is_store;
    grant        = '0;
    prev_granted = 1'b1;
    store_taken  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      is_store = RSMEM_IssueReq_Entries[i*ENTRY_LEN + RS_MEM_ISST];
      grant[i] = RSMEM_IssueReq_Valid[i] & slot_free[i] & grant_ok & ~kill_req[i] &
                 prev_granted & ~(is_store & store_taken);
      store_taken  = store_taken | (grant[i] & is_store);
      prev_granted = grant[i];
    end
  end

  assign RSMEM_Issued_Valid = grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    rsmem_issue_slot #(
      .ENTRY_LEN (ENTRY_LEN),
      .SPEC_W    (SPEC_W)
    ) u_slot (
      .clk               (clk),
      .rst               (rst),
      .flush_i           (Flush),
      .kill_enable_i     (Kill_Enable),
      .update_killmask_i (Update_KillMask),
      .spec_tag_i        (FUBR_SpecTag),
      .grant_i           (grant[g]),
      .req_entry_i       (RSMEM_IssueReq_Entries[g*ENTRY_LEN +: ENTRY_LEN]),
      .ready_i           (MEMP_Ready[g]),
      .valid_o           (MEMP_Valid[g]),
      .entry_o           (MEMP_Entries[g*ENTRY_LEN +: ENTRY_LEN]),
      .free_o            (slot_free[g])
    );
  end

`ifdef RSMEM_ISSUE_PERF_EN
  logic [PERF_W-1:0] count_q, count_d;
  logic [PERF_W-1:0] block_q, block_d;

  // Counters wrap naturally and deliberately ignore Flush.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      count_d = count_d + PERF_W'(grant[i]);
    end
    block_d = block_q + PERF_W'(RSMEM_IssueReq_Valid[0] & ~grant[0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      block_q <= '0;
    end else begin
      count_q <= count_d;
      block_q <= block_d;
    end
  end

  assign MemIssue_Count       = count_q;
  assign MemIssue_BlockCycles = block_q;
`else
  assign MemIssue_Count       = '0;
  assign MemIssue_BlockCycles = '0;
`endif

endmodule

// File: tb/tb_rsmem_issue_pipe.sv
// Directed self-checking bench for rsmem_issue_pipe (2 lanes, 4 spec tags).
module tb_rsmem_issue_pipe;
  import rsmem_issue_pipe_pkg::*;

  localparam int NR = RS_MEM_ISSUE_REQ;
  localparam int EL = RS_MEM_LEN;
  localparam int SW = SPEC_STATES;
`ifdef RSMEM_ISSUE_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             Stall, Flush, Kill_Enable, Update_KillMask;
  logic [SW-1:0]    FUBR_SpecTag;
  logic [NR*EL-1:0] RSMEM_IssueReq_Entries;
  logic [NR-1:0]    RSMEM_IssueReq_Valid;
  logic [NR-1:0]    RSMEM_Issued_Valid;
  logic [NR-1:0]    MEMP_Ready;
  logic [NR*EL-1:0] MEMP_Entries;
  logic [NR-1:0]    MEMP_Valid;
  logic [31:0]      MemIssue_Count, MemIssue_BlockCycles;

  int total = 0;
  int bad   = 0;

  rsmem_issue_pipe dut (
    .clk                    (clk),
    .rst                    (rst),
    .Stall                  (Stall),
    .Flush                  (Flush),
    .Kill_Enable            (Kill_Enable),
    .Update_KillMask        (Update_KillMask),
    .FUBR_SpecTag           (FUBR_SpecTag),
    .RSMEM_IssueReq_Entries (RSMEM_IssueReq_Entries),
    .RSMEM_IssueReq_Valid   (RSMEM_IssueReq_Valid),
    .RSMEM_Issued_Valid     (RSMEM_Issued_Valid),
    .MEMP_Ready             (MEMP_Ready),
    .MEMP_Entries           (MEMP_Entries),
    .MEMP_Valid             (MEMP_Valid),
    .MemIssue_Count         (MemIssue_Count),
    .MemIssue_BlockCycles   (MemIssue_BlockCycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EL-1:0] mk(input logic [31:0] pc, input logic st, input logic [SW-1:0] km);
    rs_mem_entry_t e;
    e.pc       = pc;
    e.op       = 3'd1;
    e.isst     = st;
    e.killmask = km;
    return e;
  endfunction

  function automatic rs_mem_entry_t port_entry(input int p);
    return rs_mem_entry_t'(MEMP_Entries[p*EL +: EL]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [EL-1:0] e0, input logic [EL-1:0] e1,
                       input logic [1:0] vld, input logic [1:0] rdy);
    RSMEM_IssueReq_Entries = {e1, e0};
    RSMEM_IssueReq_Valid   = vld;
    MEMP_Ready             = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    Stall = 1'b0; Flush = 1'b0; Kill_Enable = 1'b0; Update_KillMask = 1'b0;
    FUBR_SpecTag = '0;
    RSMEM_IssueReq_Entries = {mk(32'h10, 1'b0, 4'h0), mk(32'h14, 1'b0, 4'h0)};
    RSMEM_IssueReq_Valid   = 2'b11;
    MEMP_Ready             = 2'b11;
    #2;
    check("reset_issued", RSMEM_Issued_Valid, 2'b00);
    check("reset_memp_valid", MEMP_Valid, 2'b00);
    check("reset_memp_data", MEMP_Entries, '0);
    check("reset_count", MemIssue_Count, 0);
    check("reset_block", MemIssue_BlockCycles, 0);
    RSMEM_IssueReq_Valid = 2'b00;
    #1 rst = 1'b1;
    tick();

    // Dual load issue, then ten back-to-back dual issues at full rate.
    drive(mk(32'h100, 1'b0, 4'h0), mk(32'h104, 1'b0, 4'h0), 2'b11, 2'b11);
    check("dual_issued", RSMEM_Issued_Valid, 2'b11);
    check("dual_memp_valid_pre", MEMP_Valid, 2'b00);
    tick();
    check("dual_memp_valid", MEMP_Valid, 2'b11);
    check("dual_pc0", port_entry(0).pc, 32'h100);
    check("dual_pc1", port_entry(1).pc, 32'h104);
    for (int k = 0; k < 10; k++) begin
      drive(mk(32'h200 + 32'(k*8), 1'b0, 4'h0), mk(32'h204 + 32'(k*8), 1'b0, 4'h0), 2'b11, 2'b11);
      check("stream_issued", RSMEM_Issued_Valid, 2'b11);
      tick();
      check("stream_valid", MEMP_Valid, 2'b11);
      check("stream_pc0", port_entry(0).pc, 32'h200 + 32'(k*8));
      check("stream_pc1", port_entry(1).pc, 32'h204 + 32'(k*8));
    end

    // Strict order: port 0 stalled blocks lane 1 even with its slot free.
    drive(mk(32'h0, 1'b0, 4'h0), mk(32'h0, 1'b0, 4'h0), 2'b00, 2'b00);
    tick();
    check("hold_valid", MEMP_Valid, 2'b11);
    drive(mk(32'h500, 1'b0, 4'h0), mk(32'h504, 1'b0, 4'h0), 2'b11, 2'b10);
    check("order_drain1_issued", RSMEM_Issued_Valid, 2'b00);
    tick();
    drive(mk(32'h500, 1'b0, 4'h0), mk(32'h504, 1'b0, 4'h0), 2'b11, 2'b00);
    check("order_valid_after_drain", MEMP_Valid, 2'b01);
    check("order_blocked_issued", RSMEM_Issued_Valid, 2'b00);
    drive(mk(32'h500, 1'b0, 4'h0), mk(32'h504, 1'b0, 4'h0), 2'b11, 2'b01);
    check("order_release_issued", RSMEM_Issued_Valid, 2'b11);
    tick();
    check("order_valid", MEMP_Valid, 2'b11);
    check("order_pc0", port_entry(0).pc, 32'h500);
    check("order_pc1", port_entry(1).pc, 32'h504);

    // Two stores: only the older one issues per cycle.
    drive(mk(32'h300, 1'b1, 4'h0), mk(32'h304, 1'b1, 4'h0), 2'b11, 2'b11);
    check("st_pair_issued", RSMEM_Issued_Valid, 2'b01);
    tick();
    check("st_pair_valid", MEMP_Valid, 2'b01);
    check("st_pair_pc0", port_entry(0).pc, 32'h300);
    drive(mk(32'h304, 1'b1, 4'h0), mk(32'h0, 1'b0, 4'h0), 2'b01, 2'b11);
    check("st_second_issued", RSMEM_Issued_Valid, 2'b01);
    tick();
    check("st_second_valid", MEMP_Valid, 2'b01);
    check("st_second_pc0", port_entry(0).pc, 32'h304);

    // Branch kill on a holding uop and on a request.
    drive(mk(32'h400, 1'b0, 4'b0010), mk(32'h0, 1'b0, 4'h0), 2'b01, 2'b01);
    check("kill_load_issued", RSMEM_Issued_Valid, 2'b01);
    tick();
    check("kill_load_valid", MEMP_Valid, 2'b01);
    Kill_Enable = 1'b1; FUBR_SpecTag = 4'b0010;
    drive(mk(32'h408, 1'b0, 4'b0010), mk(32'h0, 1'b0, 4'h0), 2'b01, 2'b00);
    check("kill_hold_valid", MEMP_Valid, 2'b00);
    check("kill_req_issued", RSMEM_Issued_Valid, 2'b00);
    tick();
    Kill_Enable = 1'b0; FUBR_SpecTag = '0;
    drive(mk(32'h0, 1'b0, 4'h0), mk(32'h0, 1'b0, 4'h0), 2'b00, 2'b00);
    check("kill_after_valid", MEMP_Valid, 2'b00);

    // Correct branch resolution clears the mask bit and the uop survives.
    drive(mk(32'h410, 1'b0, 4'b0010), mk(32'h0, 1'b0, 4'h0), 2'b01, 2'b00);
    check("upd_load_issued", RSMEM_Issued_Valid, 2'b01);
    tick();
    Update_KillMask = 1'b1; FUBR_SpecTag = 4'b0010;
    drive(mk(32'h0, 1'b0, 4'h0), mk(32'h0, 1'b0, 4'h0), 2'b00, 2'b00);
    check("upd_valid", MEMP_Valid, 2'b01);
    tick();
    Update_KillMask = 1'b0;
    check("upd_mask_cleared", port_entry(0).killmask, 4'b0000);
    check("upd_pc_kept", port_entry(0).pc, 32'h410);
    Kill_Enable = 1'b1;
    #1;
    check("upd_survives_kill", MEMP_Valid, 2'b01);
    Kill_Enable = 1'b0; FUBR_SpecTag = '0;

    // Stall blocks grants but not draining.
    Stall = 1'b1;
    drive(mk(32'h700, 1'b0, 4'h0), mk(32'h704, 1'b0, 4'h0), 2'b11, 2'b01);
    check("stall_issued", RSMEM_Issued_Valid, 2'b00);
    tick();
    Stall = 1'b0;
    drive(mk(32'h0, 1'b0, 4'h0), mk(32'h0, 1'b0, 4'h0), 2'b00, 2'b00);
    check("stall_drained", MEMP_Valid, 2'b00);

    // Flush with both slots full and requests pending.
    drive(mk(32'h600, 1'b0, 4'h0), mk(32'h604, 1'b0, 4'h0), 2'b11, 2'b00);
    check("flush_fill_issued", RSMEM_Issued_Valid, 2'b11);
    tick();
    check("flush_fill_valid", MEMP_Valid, 2'b11);
    Flush = 1'b1;
    drive(mk(32'h608, 1'b0, 4'h0), mk(32'h60c, 1'b0, 4'h0), 2'b11, 2'b00);
    check("flush_issued", RSMEM_Issued_Valid, 2'b00);
    tick();
    Flush = 1'b0;
    drive(mk(32'h0, 1'b0, 4'h0), mk(32'h0, 1'b0, 4'h0), 2'b00, 2'b00);
    check("flush_valid", MEMP_Valid, 2'b00);

    // Asynchronous reset in the middle of a transfer.
    drive(mk(32'h800, 1'b0, 4'h0), mk(32'h804, 1'b0, 4'h0), 2'b11, 2'b11);
    tick();
    check("rst_pre_valid", MEMP_Valid, 2'b11);
    #1 rst = 1'b0;
    #1;
    check("rst_async_valid", MEMP_Valid, 2'b00);
    check("rst_async_issued", RSMEM_Issued_Valid, 2'b00);
    check("rst_async_data", MEMP_Entries, '0);
    RSMEM_IssueReq_Valid = 2'b00;
    MEMP_Ready = 2'b00;
    #1 rst = 1'b1;
    tick();

    // Counters: five dual-grant cycles, then three cycles with lane 0 blocked.
    for (int k = 0; k < 5; k++) begin
      drive(mk(32'h900 + 32'(k*8), 1'b0, 4'h0), mk(32'h904 + 32'(k*8), 1'b0, 4'h0), 2'b11, 2'b11);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(mk(32'ha00, 1'b0, 4'h0), mk(32'ha04, 1'b0, 4'h0), 2'b11, 2'b00);
      tick();
    end
    drive(mk(32'h0, 1'b0, 4'h0), mk(32'h0, 1'b0, 4'h0), 2'b00, 2'b00);
    check("perf_count", MemIssue_Count, PERF_ON ? 64'd10 : 64'd0);
    check("perf_block", MemIssue_BlockCycles, PERF_ON ? 64'd3 : 64'd0);
    check("perf_slots_full", MEMP_Valid, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsmem_issue_pipe.md
Name: rsmem_issue_pipe

Overview:
- Issue-select and issue-register stage directly downstream of the memory reservation station.
- Each cycle it takes up to NUM_REQ in-order issue requests from the memory RS and grants them in strict age order. It returns the issue confirmations (RSMEM_Issued_Valid) to the RS in the same cycle.
- Granted uops are captured into one holding register per memory port. Each register presents its uop to the AGU/LSU port with a valid/ready handshake.
- Branch kill, kill-mask update and flush are applied to in-flight uops.

Parameters:
- NUM_REQ, `RS_MEM_ISSUE_REQ (2), number of issue request lanes = number of memory ports.
- ENTRY_LEN, `RS_MEM_LEN, width of one RS memory entry.
- SPEC_W, `SPEC_STATES, speculation tag / kill-mask width.
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, active-low, asynchronous assert.
- Stall  in  1  backend stall; blocks new grants.
- Flush  in  1  pipeline flush.
- Kill_Enable  in  1  branch mispredicted.
- Update_KillMask  in  1  branch resolved correct; clear its tag bit.
- FUBR_SpecTag  in  SPEC_W  one-hot tag of the resolving branch.
- RSMEM_IssueReq_Entries  in  NUM_REQ*ENTRY_LEN  requested entries; lane 0 is oldest.
- RSMEM_IssueReq_Valid  in  NUM_REQ  request valid per lane.
- RSMEM_Issued_Valid  out  NUM_REQ  grant/confirmation per lane (combinational).
- MEMP_Ready  in  NUM_REQ  memory port i accepts this cycle.
- MEMP_Entries  out  NUM_REQ*ENTRY_LEN  uop presented on port i.
- MEMP_Valid  out  NUM_REQ  port i uop valid.
- MemIssue_Count  out  PERF_W  total uops granted (optional feature).
- MemIssue_BlockCycles  out  PERF_W  cycles with lane 0 requesting but not granted (optional feature).

Behaviour:
- Reset (rst=0, async): all holding valids=0, holding data=0, counters=0. MEMP_Valid=0 and RSMEM_Issued_Valid=0 while in reset.
- Per-lane kill hit: KillReq[i] = Kill_Enable & |(FUBR_SpecTag & killmask of request i). KillHold[i] is the same term computed on holding register i.
- Slot free: Free[i] = ~HV[i] | (MEMP_Valid[i] & MEMP_Ready[i]) | KillHold[i].
- Grant[i] = ReqValid[i] & Free[i] & ~Stall & ~Flush & ~KillReq[i] & (i==0 | Grant[i-1]) & ~StoreConflict[i].
  - Strict order: a lane is never granted unless every lower lane is granted.
  - StoreConflict[i] = entry i has `RS_MEM_ISST set and some granted lane j<i is also a store. At most one store issues per cycle (single store-data path).
- RSMEM_Issued_Valid = Grant, same cycle, no register. The RS consumes it at the same clock edge.
- Holding register update, evaluated in priority order:
  - Flush → HV=0.
  - Grant[i] → HV=1 and HD=request i. If Update_KillMask, the killmask is loaded with the FUBR_SpecTag bits cleared.
  - Handshake (MEMP_Valid & MEMP_Ready) or KillHold → HV=0.
  - Otherwise hold HD. Apply killmask clear on Update_KillMask.
- A drain and a new grant in the same cycle refill the slot back-to-back, giving full throughput (1 uop/port/cycle).
- MEMP_Valid[i] = HV[i] & ~KillHold[i]. A uop killed this cycle is never transferred. MEMP_Entries[i] = HD[i].
- Latency: request to MEMP_Valid is 1 cycle.
- Stall does not block draining of the holding registers.
- Kill_Enable and Update_KillMask are mutually exclusive by contract. If both are asserted, the kill takes effect.
- Flush overrides grant, kill and handshake. Grant is 0 during Flush.
- Holding data is only meaningful when HV=1.

Optional Feature:
- RSMEM_ISSUE_PERF_EN defined:
  - MemIssue_Count increments by popcount(Grant) each cycle.
  - MemIssue_BlockCycles increments when ReqValid[0] & ~Grant[0].
  - Both counters wrap modulo 2^PERF_W, are not cleared by Flush, and are cleared by reset.
- RSMEM_ISSUE_PERF_EN undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- `RS_MEM_ISSUE_REQ, `RS_MEM_LEN, `SPEC_STATES live in core_defines.vh.
- RS field positions live in regbit_defines.vh, with the new `RS_MEM_ISST store-flag field added there.
- Natural sub-module: rsmem_issue_slot, one holding register with kill, killmask update, handshake and flush. Instantiated NUM_REQ times.
- Grant logic stays in the top.

Test Plan:
- Two ready loads, both MEMP_Ready=1 → Issued_Valid=2'b11 in the same cycle; next cycle MEMP_Valid=2'b11 with matching PCs; 1 uop/port/cycle sustained over 10 back-to-back cycles.
- Lane 0 valid, MEMP_Ready[0]=0 and HV[0]=1 → Issued_Valid=2'b00 even though lane 1 is valid and its slot is free (strict order). Raise MEMP_Ready[0] → Issued_Valid=2'b11 in that same cycle.
- Two stores requested → Issued_Valid=2'b01. The next cycle, store 2 is in lane 0 and granted.
- Holding uop with killmask=4'b0010, Kill_Enable=1, FUBR_SpecTag=4'b0010 → MEMP_Valid drops in that cycle and HV=0 next cycle. Same case with Update_KillMask instead → killmask becomes 4'b0000 and the uop survives.
- Flush with both slots full and requests pending → Issued_Valid=0, MEMP_Valid=0 next cycle. Assert rst low mid-transfer → outputs 0 asynchronously.
- With RSMEM_ISSUE_PERF_EN: 5 cycles of dual grant followed by 3 blocked cycles → Count=10, BlockCycles=3.
